// File: rtl/vram_arb_defs_pkg.sv
// Shared encodings for the VRAM arbiter: FSM states, grant owner and a small sizing helper.
`timescale 1ns/1ps
package vram_arb_defs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    typedef enum logic {
        OWN_VID = 1'b0,
        OWN_CPU = 1'b1
    } owner_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/vram_arb_grant_m.sv
// Grant pick for the VRAM arbiter: video has priority, and a burst counter bounds how many
// consecutive video grants may pass while the CPU waits.
`timescale 1ns/1ps
module vram_arb_grant_m #(
    parameter int VID_BURST_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic arb_en,
    input  logic vid_req,
    input  logic cpu_req,
    output logic grant_vid,
    output logic grant_cpu
);
    localparam int BW = $clog2(VID_BURST_MAX + 1);

    logic [BW-1:0] burst_q, burst_d;
    logic          starved;

    always_comb begin
        starved   = cpu_req && (burst_q == BW'(VID_BURST_MAX));
        grant_vid = arb_en && vid_req && !starved;
        grant_cpu = arb_en && cpu_req && !grant_vid;
        burst_d   = burst_q;
        // A video grant with the CPU waiting implies burst_q < VID_BURST_MAX, so no overflow.
        if (arb_en) begin
            if (grant_cpu || !cpu_req) begin
                burst_d = '0;
            end else if (grant_vid) begin
                burst_d = burst_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            burst_q <= '0;
        end else begin
            burst_q <= burst_d;
        end
    end

endmodule

// File: rtl/vram_arbiter_m.sv
// Two-port arbiter/sequencer for the asynchronous video RAM (IDLE/SETUP/ACCESS/HOLD).
// Optional grant statistics are compiled in with VRAM_ARB_STATS_EN.
`timescale 1ns/1ps
module vram_arbiter_m
    import vram_arb_defs_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 15,
    parameter int RD_CYCLES     = 1,
    parameter int WR_CYCLES     = 1,
    parameter int VID_BURST_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  vid_req,
    input  logic [ADDR_WIDTH-1:0] vid_addr,
    output logic                  vid_ack,
    output logic [DATA_WIDTH-1:0] vid_rdata,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ack,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic [ADDR_WIDTH-1:0] ram_address,
    inout  wire  [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_we,
    output logic                  ram_oe
`ifdef VRAM_ARB_STATS_EN
    ,
    input  logic                  stats_clr,
    output logic [15:0]           vid_grant_cnt,
    output logic [15:0]           cpu_grant_cnt
`endif
);
    localparam int CW = $clog2(max2(RD_CYCLES, WR_CYCLES) + 1);

    state_t                state_q, state_d;
    owner_t                own_q, own_d;
    logic                  wr_q, wr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [ADDR_WIDTH-1:0] ram_address_q, ram_address_d;
    logic                  ram_we_q, ram_we_d;
    logic                  ram_oe_q, ram_oe_d;
    logic                  ram_we_drv_q, ram_we_drv_d;
    logic                  vid_ack_q, vid_ack_d;
    logic                  cpu_ack_q, cpu_ack_d;
    logic [DATA_WIDTH-1:0] vid_rdata_q, vid_rdata_d;
    logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
    logic                  grant_vid, grant_cpu;

    vram_arb_grant_m #(
        .VID_BURST_MAX(VID_BURST_MAX)
    ) u_grant (
        .clk      (clk),
        .rst      (rst),
        .arb_en   (state_q == ST_IDLE),
        .vid_req  (vid_req),
        .cpu_req  (cpu_req),
        .grant_vid(grant_vid),
        .grant_cpu(grant_cpu)
    );

    always_comb begin
        state_d       = state_q;
        own_d         = own_q;
        wr_d          = wr_q;
        cnt_d         = cnt_q;
        wdata_d       = wdata_q;
        ram_address_d = ram_address_q;
        ram_we_d      = ram_we_q;
        ram_oe_d      = ram_oe_q;
        ram_we_drv_d  = ram_we_drv_q;
        vid_ack_d     = 1'b0;
        cpu_ack_d     = 1'b0;
        vid_rdata_d   = vid_rdata_q;
        cpu_rdata_d   = cpu_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_vid || grant_cpu) begin
                    own_d         = grant_cpu ? OWN_CPU : OWN_VID;
                    wr_d          = grant_cpu && cpu_we;
                    ram_address_d = grant_cpu ? cpu_addr : vid_addr;
                    wdata_d       = cpu_wdata;
                    // Driver comes on with the address so data is settled a full cycle before WE.
                    ram_we_drv_d  = grant_cpu && cpu_we;
                    state_d       = ST_SETUP;
                end
            end
            ST_SETUP: begin
                ram_we_d = wr_q;
                ram_oe_d = !wr_q;
                cnt_d    = wr_q ? CW'(WR_CYCLES - 1) : CW'(RD_CYCLES - 1);
                state_d  = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (cnt_q == '0) begin
                    ram_we_d = 1'b0;
                    ram_oe_d = 1'b0;
                    if (!wr_q) begin
                        if (own_q == OWN_CPU) cpu_rdata_d = ram_data;
                        else                  vid_rdata_d = ram_data;
                    end
                    vid_ack_d = (own_q == OWN_VID);
                    cpu_ack_d = (own_q == OWN_CPU);
                    state_d   = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                ram_we_drv_d = 1'b0;
                state_d      = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            own_q         <= OWN_VID;
            wr_q          <= 1'b0;
            cnt_q         <= '0;
            wdata_q       <= '0;
            ram_address_q <= '0;
            ram_we_q      <= 1'b0;
            ram_oe_q      <= 1'b0;
            ram_we_drv_q  <= 1'b0;
            vid_ack_q     <= 1'b0;
            cpu_ack_q     <= 1'b0;
            vid_rdata_q   <= '0;
            cpu_rdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            own_q         <= own_d;
            wr_q          <= wr_d;
            cnt_q         <= cnt_d;
            wdata_q       <= wdata_d;
            ram_address_q <= ram_address_d;
            ram_we_q      <= ram_we_d;
            ram_oe_q      <= ram_oe_d;
            ram_we_drv_q  <= ram_we_drv_d;
            vid_ack_q     <= vid_ack_d;
            cpu_ack_q     <= cpu_ack_d;
            vid_rdata_q   <= vid_rdata_d;
            cpu_rdata_q   <= cpu_rdata_d;
        end
    end

    assign ram_data    = ram_we_drv_q ? wdata_q : {DATA_WIDTH{1'bz}};
    assign ram_address = ram_address_q;
    assign ram_we      = ram_we_q;
    assign ram_oe      = ram_oe_q;
    assign vid_ack     = vid_ack_q;
    assign cpu_ack     = cpu_ack_q;
    assign vid_rdata   = vid_rdata_q;
    assign cpu_rdata   = cpu_rdata_q;

`ifdef VRAM_ARB_STATS_EN
    logic [15:0] vid_cnt_q, vid_cnt_d;
    logic [15:0] cpu_cnt_q, cpu_cnt_d;

    always_comb begin
        vid_cnt_d = vid_cnt_q;
        cpu_cnt_d = cpu_cnt_q;
        if (stats_clr) begin
            vid_cnt_d = '0;
            cpu_cnt_d = '0;
        end else begin
            if (vid_ack_q && (vid_cnt_q != 16'hFFFF)) vid_cnt_d = vid_cnt_q + 16'd1;
            if (cpu_ack_q && (cpu_cnt_q != 16'hFFFF)) cpu_cnt_d = cpu_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vid_cnt_q <= '0;
            cpu_cnt_q <= '0;
        end else begin
            vid_cnt_q <= vid_cnt_d;
            cpu_cnt_q <= cpu_cnt_d;
        end
    end

    assign vid_grant_cnt = vid_cnt_q;
    assign cpu_grant_cnt = cpu_cnt_q;
`endif

endmodule
